triad_decoder_bank: RTL and testbench
=====================================

// Module: triad_decoder_bank
// PURPOSE
// - Parametrised bank of NCH distrip triad decoders for the comparator test stand.
// - Each channel parses a serial 3-bit triad on distrip[i] into a one-hot 4-bit half-strip group.
// - Adds per-channel masking, programmable output persistence and skip flags.
// - Adds an optional saturating skip counter for readout over the serial port.
// - Sits between the comparator distrip pins and the half-strip compare logic in comparator_injector.
// PARAMETERS
// - NCH  8   number of distrip channels; halfstrips width = 4*NCH
// - PW   4   persist input width
// - CW   16  skip_count width
// PORTS
// - clock40       in   1      40 MHz clock; all logic on rising edge
// - lctrst        in   1      synchronous active-high reset
// - distrip       in   NCH    serial triad inputs, one per channel
// - persist       in   PW     output persistence minus 1 (5 -> 6-clk width)
// - persist1      in   1      1: force persistence to exactly 1 clk, ignore persist
// - ch_mask       in   NCH    1 = channel disabled
// - skip_cnt_rst  in   1      synchronous clear of skip_count
// - halfstrips    out  4*NCH  channel i drives bits [4i+3:4i]
// - tskip         out  NCH    1-clk pulse: channel i dropped a completed triad
// - triad_skip    out  1      OR of tskip, same cycle
// - busy          out  NCH    channel FSM not in IDLE
// - skip_count    out  CW     total skipped triads, saturating
// BEHAVIOUR
// - Reset: all outputs, FSMs, persistence counters and skip_count are 0 on the edge after lctrst=1.
// - Reset mid-triad or mid-persistence aborts the operation; nothing completes later.
// - Per-channel FSM: IDLE -(distrip=1)-> B1 (latch t1) -> B2 (latch t2) -> IDLE.
//   - The triad completes on the B2 edge.
//   - A new start bit is accepted the cycle after B2.
// - Decode: half-strip index = {t1,t2}.
//   - 00 -> 0001, 01 -> 0010, 10 -> 0100, 11 -> 1000.
// - Latency: start bit sampled at edge n; the one-hot group is registered at edge n+3.
// - Width: W = persist1 ? 1 : persist+1, so persist=0 gives 1 clk.
//   - W is sampled at triad completion; later changes to persist do not affect a running output.
// - Persistence counter pc, per channel:
//   - On accept: group <= one-hot, pc <= W-1.
//   - Each later cycle: if pc>0 then pc-1; else group <= 0.
// - Skip: a triad that completes while pc>0 is dropped.
//   - The group and pc are unchanged.
//   - tskip[i] pulses 1 clk, aligned with the edge where the accept would have happened.
// - A triad completing when pc==0 (last persistence cycle) is accepted.
//   - The group is replaced back-to-back with no gap.
// - ch_mask[i]=1 forces: FSM to IDLE, group=0, pc=0, tskip[i]=0.
//   - This takes effect on the next edge, including mid-triad.
//   - Deasserting the mask resumes with start-bit search.
// - busy[i] = (state != IDLE).
// CONFIGURATION
// - TRIAD_SKIP_CNT_EN defined:
//   - skip_count += popcount(tskip) each cycle, saturating at 2^CW-1.
//   - skip_cnt_rst clears it; when it coincides with skips, the clear wins and the result is 0.
// - TRIAD_SKIP_CNT_EN undefined:
//   - skip_count tied to 0 and no counter logic is built.
//   - skip_cnt_rst is ignored.
//   - tskip and triad_skip are unchanged.
// TESTING
// - lctrst=1 for 2 clk with distrip=all 1 -> all outputs 0; the first triad decodes normally after release.
// - ch0 serial 1,1,0 (start at edge n), persist1=1 -> halfstrips[3:0]=0100 at edge n+3 only.
//   - busy[0] is high for 2 clk.
// - ch3 1,0,1, persist=5, persist1=0 -> halfstrips[15:12]=0010 for exactly 6 clk.
//   - A second triad 1,1,1 completing 2 clk later -> tskip[3]=1 for 1 clk, triad_skip=1.
//   - The output stays 0010; skip_count=1 with TRIAD_SKIP_CNT_EN, 0 without.
// - persist=2, back-to-back triads 1,0,0 then 1,1,1 on ch7 -> 0001 for 3 clk, then immediately 1000.
//   - No skip.
// - ch_mask[1] asserted after start bit -> busy[1]=0 next clk and no output.
//   - Clear the mask, then send 1,0,0 -> 0001.
// - All 8 channels skip in the same cycle, TRIAD_SKIP_CNT_EN, CW=4, count at 12 -> 15 (saturates).
//   - Repeat with skip_cnt_rst=1 -> 0.

Source files
------------

// File: rtl/triad_decoder_bank.sv
// Bank of NCH serial triad decoders: start bit + 2 data bits -> one-hot half-strip group with persistence.
// Latency: start bit sampled at edge n, one-hot group registered at edge n+3.
// No backpressure: a triad completing while the previous output still persists is dropped and flagged on tskip.
// Optional feature macro: TRIAD_SKIP_CNT_EN builds the saturating skip_count; otherwise skip_count is tied to 0.
module triad_decoder_bank #(
    parameter int NCH = 8,
    parameter int PW  = 4,
    parameter int CW  = 16
) (
    input  logic               clock40,
    input  logic               lctrst,
    input  logic [NCH-1:0]     distrip,
    input  logic [PW-1:0]      persist,
    input  logic               persist1,
    input  logic [NCH-1:0]     ch_mask,
    input  logic               skip_cnt_rst,
    output logic [4*NCH-1:0]   halfstrips,
    output logic [NCH-1:0]     tskip,
    output logic               triad_skip,
    output logic [NCH-1:0]     busy,
    output logic [CW-1:0]      skip_count
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_B1   = 2'd1,
        S_B2   = 2'd2
    } state_t;

    state_t          r_state     [NCH];
    state_t          w_state_nxt [NCH];
    logic [NCH-1:0]  r_t1;
    logic [NCH-1:0]  r_done;       // triad completed on the previous edge, decision pending
    logic [1:0]      r_code      [NCH];
    logic [PW-1:0]   r_pcw       [NCH];  // persistence count captured at completion (W-1)
    logic [PW-1:0]   r_pc        [NCH];
    logic [3:0]      r_group     [NCH];
    logic [NCH-1:0]  r_tskip;
    logic [NCH-1:0]  w_skip;

    // Next-state logic for every channel FSM; mask forces IDLE on the next edge
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            w_state_nxt[i] = r_state[i];
            case (r_state[i])
                S_IDLE:  if (distrip[i]) w_state_nxt[i] = S_B1;
                S_B1:    w_state_nxt[i] = S_B2;
                S_B2:    w_state_nxt[i] = S_IDLE;
                default: w_state_nxt[i] = S_IDLE;
            endcase
            if (ch_mask[i]) w_state_nxt[i] = S_IDLE;
        end
    end

    // A pending triad is dropped when the current output still has cycles left after this one
    always_comb begin
        w_skip = '0;
        for (int i = 0; i < NCH; i++) begin
            w_skip[i] = r_done[i] && (r_pc[i] != '0) && !ch_mask[i];
        end
    end

    // FSM state registers
    always_ff @(posedge clock40) begin
        for (int i = 0; i < NCH; i++) begin
            if (lctrst) r_state[i] <= S_IDLE;
            else        r_state[i] <= w_state_nxt[i];
        end
    end

    // Bit capture, accept/skip decision and persistence countdown per channel
    always_ff @(posedge clock40) begin
        for (int i = 0; i < NCH; i++) begin
            if (lctrst || ch_mask[i]) begin
                r_t1[i]    <= 1'b0;
                r_done[i]  <= 1'b0;
                r_code[i]  <= '0;
                r_pcw[i]   <= '0;
                r_pc[i]    <= '0;
                r_group[i] <= '0;
                r_tskip[i] <= 1'b0;
            end else begin
                if (r_state[i] == S_B1) r_t1[i] <= distrip[i];
                r_done[i] <= (r_state[i] == S_B2);
                if (r_state[i] == S_B2) begin
                    r_code[i] <= {r_t1[i], distrip[i]};
                    r_pcw[i]  <= persist1 ? '0 : persist;
                end
                r_tskip[i] <= w_skip[i];
                // A dropped triad leaves group and countdown running as if nothing arrived
                if (r_done[i] && (r_pc[i] == '0)) begin
                    r_group[i] <= 4'b0001 << r_code[i];
                    r_pc[i]    <= r_pcw[i];
                end else if (r_pc[i] != '0) begin
                    r_pc[i] <= r_pc[i] - 1'b1;
                end else begin
                    r_group[i] <= '0;
                end
            end
        end
    end

    // Output mapping
    always_comb begin
        halfstrips = '0;
        busy       = '0;
        for (int i = 0; i < NCH; i++) begin
            halfstrips[4*i +: 4] = r_group[i];
            busy[i]              = (r_state[i] != S_IDLE);
        end
    end

    assign tskip      = r_tskip;
    assign triad_skip = |r_tskip;

`ifdef TRIAD_SKIP_CNT_EN
    localparam int PCW = $clog2(NCH + 1);
    localparam int SW  = CW + PCW;
    localparam logic [CW-1:0] CNT_MAX = '1;

    logic [PCW-1:0] w_pop;
    logic [SW-1:0]  w_sum;
    logic [CW-1:0]  r_skip_cnt;

    // Number of channels dropping a triad on this edge
    always_comb begin
        w_pop = '0;
        for (int i = 0; i < NCH; i++) begin
            w_pop = w_pop + PCW'(w_skip[i]);
        end
        w_sum = SW'(r_skip_cnt) + SW'(w_pop);
    end

    // Saturating skip counter; a clear beats simultaneous skips
    always_ff @(posedge clock40) begin
        if (lctrst || skip_cnt_rst)   r_skip_cnt <= '0;
        else if (w_sum > SW'(CNT_MAX)) r_skip_cnt <= CNT_MAX;
        else                          r_skip_cnt <= w_sum[CW-1:0];
    end

    assign skip_count = r_skip_cnt;
`else
    logic w_unused_skip_cnt_rst;
    assign w_unused_skip_cnt_rst = skip_cnt_rst;
    assign skip_count = '0;
`endif

endmodule

// File: tb/tb_triad_decoder_bank.sv
// Randomized plus directed stimulus against a cycle-level behavioural model of the triad decoder bank.
// Expected outputs per edge are queued by the stimulus side and compared by an independent monitor.
// Directed sequences cover reset, decode, persistence, skips, back-to-back, masking and counter saturation.
module tb_triad_decoder_bank;
    localparam int NCH = 8;
    localparam int PW  = 4;
    localparam int CW  = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic [NCH-1:0]     distrip = '0;
    logic [PW-1:0]      persist = '0;
    logic               persist1 = 1'b0;
    logic [NCH-1:0]     ch_mask = '0;
    logic               skip_cnt_rst = 1'b0;
    logic [4*NCH-1:0]   halfstrips;
    logic [NCH-1:0]     tskip;
    logic               triad_skip;
    logic [NCH-1:0]     busy;
    logic [CW-1:0]      skip_count;

    triad_decoder_bank #(.NCH(NCH), .PW(PW), .CW(CW)) dut (
        .clock40     (clk),
        .lctrst      (rst),
        .distrip     (distrip),
        .persist     (persist),
        .persist1    (persist1),
        .ch_mask     (ch_mask),
        .skip_cnt_rst(skip_cnt_rst),
        .halfstrips  (halfstrips),
        .tskip       (tskip),
        .triad_skip  (triad_skip),
        .busy        (busy),
        .skip_count  (skip_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4*NCH-1:0] hs;
        logic [NCH-1:0]   ts;
        logic             trs;
        logic [NCH-1:0]   bsy;
        logic [CW-1:0]    cnt;
    } exp_t;

    exp_t q[$];
    int   total  = 0;
    int   passed = 0;
    int   cyc    = 0;

    // Behavioural model: bits_seen = bits of current triad received so far (0 = hunting for start),
    // rem = cycles the displayed group remains visible, counting the current one.
    int bits_seen [NCH];
    int first_bit [NCH];
    int pend      [NCH];
    int pend_idx  [NCH];
    int pend_w    [NCH];
    int rem       [NCH];
    int shown_idx [NCH];
    int m_cnt;

    // Stimulus globals applied on every driven cycle
    int         g_pers  = 0;
    logic       g_p1    = 1'b0;
    logic [7:0] g_mask  = '0;
    logic       g_scr   = 1'b0;
    logic       g_rst   = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s @cycle %0d: got %h expected %h", nm, cyc, act, exp);
    endtask

    // Advance the model by one clock edge for the given inputs and return the outputs after that edge
    task automatic model_step(input logic [NCH-1:0] d, output exp_t e);
        int nsk;
        nsk = 0;
        e.hs = '0; e.ts = '0; e.bsy = '0;
        for (int i = 0; i < NCH; i++) begin
            if (g_rst || g_mask[i]) begin
                bits_seen[i] = 0; pend[i] = 0; rem[i] = 0;
            end else begin
                if (pend[i] != 0) begin
                    if (rem[i] > 1) begin
                        e.ts[i] = 1'b1; nsk++; rem[i] = rem[i] - 1;
                    end else begin
                        shown_idx[i] = pend_idx[i]; rem[i] = pend_w[i];
                    end
                end else if (rem[i] > 0) begin
                    rem[i] = rem[i] - 1;
                end
                pend[i] = 0;
                if (bits_seen[i] == 0) begin
                    if (d[i]) bits_seen[i] = 1;
                end else if (bits_seen[i] == 1) begin
                    first_bit[i] = int'(d[i]); bits_seen[i] = 2;
                end else begin
                    pend[i] = 1;
                    pend_idx[i] = 2 * first_bit[i] + int'(d[i]);
                    pend_w[i] = g_p1 ? 1 : g_pers + 1;
                    bits_seen[i] = 0;
                end
            end
            if (rem[i] > 0) e.hs[4*i + shown_idx[i]] = 1'b1;
            e.bsy[i] = (bits_seen[i] != 0);
        end
`ifdef TRIAD_SKIP_CNT_EN
        if (g_rst || g_scr) m_cnt = 0;
        else m_cnt = (m_cnt + nsk > CMAX) ? CMAX : m_cnt + nsk;
`else
        m_cnt = 0;
`endif
        e.trs = |e.ts;
        e.cnt = CW'(m_cnt);
    endtask

    task automatic drive(input logic [NCH-1:0] d);
        exp_t e;
        @(negedge clk);
        distrip      = d;
        persist      = PW'(g_pers);
        persist1     = g_p1;
        ch_mask      = g_mask;
        skip_cnt_rst = g_scr;
        rst          = g_rst;
        model_step(d, e);
        q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive('0);
    endtask

    task automatic triad(input logic [NCH-1:0] chs, input logic a, input logic b);
        drive(chs);
        drive(a ? chs : '0);
        drive(b ? chs : '0);
    endtask

    // Monitor: compare every edge's outputs with the queued expectation
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("halfstrips", 64'(halfstrips), 64'(e.hs));
                chk("tskip",      64'(tskip),      64'(e.ts));
                chk("triad_skip", 64'(triad_skip), 64'(e.trs));
                chk("busy",       64'(busy),       64'(e.bsy));
                chk("skip_count", 64'(skip_count), 64'(e.cnt));
            end
        end
    end

    initial begin
        for (int i = 0; i < NCH; i++) begin
            bits_seen[i] = 0; first_bit[i] = 0; pend[i] = 0; pend_idx[i] = 0;
            pend_w[i] = 1; rem[i] = 0; shown_idx[i] = 0;
        end
        m_cnt = 0;

        // Reset held with all inputs high
        g_rst = 1'b1; drive('1); drive('1); g_rst = 1'b0;
        idle(2);

        // ch0 1,1,0 single-cycle pulse
        g_p1 = 1'b1; triad(8'h01, 1'b1, 1'b0); idle(5);

        // ch3 1,0,1 persist 5, then 1,1,1 dropped
        g_p1 = 1'b0; g_pers = 5;
        triad(8'h08, 1'b0, 1'b1); triad(8'h08, 1'b1, 1'b1); idle(8);

        // ch7 back-to-back with persist 2
        g_pers = 2;
        triad(8'h80, 1'b0, 1'b0); triad(8'h80, 1'b1, 1'b1); idle(6);

        // ch1 masked after start bit, then normal triad
        drive(8'h02); g_mask = 8'h02; drive(8'h02); drive('0); g_mask = '0;
        idle(2); triad(8'h02, 1'b0, 1'b0); idle(4);

        // Reset in the middle of a triad
        drive(8'h10); g_rst = 1'b1; drive(8'h10); g_rst = 1'b0; idle(5);

        // Skip counter: 8, then 12, then saturate, then clear winning over skips
        g_pers = 7; g_scr = 1'b1; drive('0); g_scr = 1'b0;
        triad(8'hFF, 1'b1, 1'b0); triad(8'hFF, 1'b0, 1'b1); idle(10);
        triad(8'h0F, 1'b0, 1'b0); triad(8'h0F, 1'b1, 1'b1); idle(10);
        triad(8'hFF, 1'b1, 1'b1); triad(8'hFF, 1'b0, 1'b0); idle(10);
        triad(8'hFF, 1'b0, 1'b1); g_scr = 1'b1; triad(8'hFF, 1'b1, 1'b0); idle(3); g_scr = 1'b0;
        idle(10);

        // Randomized traffic
        for (int k = 0; k < 2000; k++) begin
            if ($urandom_range(0, 15) == 0) g_pers = $urandom_range(0, 15);
            if ($urandom_range(0, 15) == 0) g_p1 = ($urandom_range(0, 7) == 0);
            g_mask = ($urandom_range(0, 15) == 0) ? 8'($urandom) : '0;
            g_scr  = ($urandom_range(0, 31) == 0);
            g_rst  = ($urandom_range(0, 199) == 0);
            drive(8'($urandom));
        end
        g_mask = '0; g_scr = 1'b0; g_rst = 1'b0;
        idle(20);

        @(posedge clk);
        #2;
        chk("queue_drained", 64'(q.size()), 64'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
